// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared types and constants for the RAM arbiter
package ram_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} arb_state_t;

    localparam int RAM_W = 8;

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester-side bundle between masters and the arbiter
interface ram_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int W     = 8
);

    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        we;
    logic [N_REQ-1:0][W-1:0] addr;
    logic [N_REQ-1:0][W-1:0] wdata;
    logic [N_REQ-1:0]        ack;
    logic [N_REQ-1:0][W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/ram.sv
// rtl/ram.sv - single-port RAM with two-phase (address, then data) bus protocol
module ram
    import ram_arbiter_pkg::*;
#(
    parameter int W = RAM_W
) (
    input  logic         clock,
    input  logic         enable,
    input  logic         rw,
    inout  wire  [W-1:0] bus
);

    logic [W-1:0] memory [0:(2**W)-1];
    logic [W-1:0] a;
    logic         phase;

    // phase=0 expects an address beat, phase=1 the data beat; idle cycles resync it
    always_ff @(posedge clock) begin
        if (!enable) begin
            phase <= 1'b0;
        end else if (!phase) begin
            a     <= bus;
            phase <= 1'b1;
        end else begin
            if (rw) memory[a] <= bus;
            phase <= 1'b0;
        end
    end

    assign bus = (enable && phase && !rw) ? memory[a] : 'z;

endmodule

// File: rtl/ram_arbiter_rr_picker.sv
// rtl/ram_arbiter_rr_picker.sv - combinational round-robin search starting at ptr
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (int'(ptr) + i) % N;
            if (!grant_valid && req[j] && !mask[j]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin sharing of a two-phase single-port RAM bus
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int W     = RAM_W
) (
    input  logic         clock,
    input  logic         reset,
    ram_arbiter_if.slave rif,
    output logic         enable,
    output logic         rw,
    inout  wire  [W-1:0] bus
);

    localparam int IW = $clog2(N_REQ);

    arb_state_t       state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    grant;
    logic             we_q;
    logic [W-1:0]     wdata_q;
    logic             bus_oe;
    logic [W-1:0]     bus_q;
    logic [N_REQ-1:0] mask;
    logic             gv;
    logic [IW-1:0]    gidx;

    // the requester being acked still holds req, so keep it out of this decision
    assign mask = (state == DONE) ? (N_REQ'(1) << grant) : '0;

    rr_picker #(.N(N_REQ), .IW(IW)) u_picker (
        .req         (rif.req),
        .mask        (mask),
        .ptr         (ptr),
        .grant_valid (gv),
        .grant_idx   (gidx)
    );

    assign bus = bus_oe ? bus_q : 'z;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            grant     <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            enable    <= 1'b0;
            rw        <= 1'b0;
            bus_oe    <= 1'b0;
            bus_q     <= '0;
            rif.ack   <= '0;
            rif.rdata <= '0;
        end else begin
            rif.ack <= '0;
            case (state)
                IDLE, DONE: begin
                    if (gv) begin
                        grant   <= gidx;
                        ptr     <= (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
                        we_q    <= rif.we[gidx];
                        wdata_q <= rif.wdata[gidx];
                        enable  <= 1'b1;
                        rw      <= rif.we[gidx];
                        bus_oe  <= 1'b1;
                        bus_q   <= rif.addr[gidx];
                        state   <= ADDR;
                    end else begin
                        enable  <= 1'b0;
                        bus_oe  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                ADDR: begin
                    bus_oe <= we_q;
                    bus_q  <= wdata_q;
                    state  <= DATA;
                end
                DATA: begin
                    if (!we_q) rif.rdata[grant] <= bus;
                    rif.ack[grant] <= 1'b1;
                    enable <= 1'b0;
                    rw     <= 1'b0;
                    bus_oe <= 1'b0;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port `ram` block among `N_REQ` requesters and sequences the two-phase RAM bus protocol: an address phase, then a data phase on the shared 8-bit `bus` qualified by `enable`/`rw`. It sits between the requesting masters (CPU core, loader, debug port) and `ram`. It grants one request at a time in round-robin order and returns a one-cycle `ack` per completed transfer, with read data for reads.

## Interface
- `N_REQ`, default 2: number of requesters, at least 2.
- `W`, default 8: address and data width. Must match the `ram` bus width.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  N_REQ: per-requester request, level.
- `we`  in  N_REQ: per-requester direction, 1 = write, 0 = read.
- `addr`  in  N_REQ×W: per-requester address.
- `wdata`  in  N_REQ×W: per-requester write data.
- `ack`  out  N_REQ: one-cycle completion pulse, one-hot or zero.
- `rdata`  out  N_REQ×W: per-requester read data, held until that requester's next read completes.
- `enable`  out  1: to `ram`.
- `rw`  out  1: to `ram`, 1 = write.
- `bus`  inout  W: shared RAM bus. The arbiter drives it only while `bus_oe` is high; otherwise it is `'z`.

## Operation
- FSM states are IDLE, ADDR, DATA and DONE.
- **IDLE**: `enable`=0, bus released. If any `req` is set, pick the winner by round-robin. Latch its `we`, `addr` and `wdata` into internal registers, record the grant index, then go to ADDR.
- **ADDR**: `enable`=1, `rw`=latched `we`, bus driven with latched `addr`. Always go to DATA.
- **DATA**: `enable`=1, `rw`=latched `we`.
  - Write: bus driven with latched `wdata`.
  - Read: bus released; `ram` drives it. Sample `bus` at the closing edge into `rdata[grant]`.
  - Always go to DONE.
- **DONE**: `enable`=0, bus released, `ack[grant]`=1.
  - Arbitration also runs in this state. The requester being acked is masked out for this one decision, because its `req` is still high.
  - A winner goes directly to ADDR with its fields latched. With no winner, go to IDLE.
- **Round-robin**:
  - The priority pointer is set to one past the last granted index, modulo N_REQ.
  - After reset the pointer is 0, so requester 0 wins a tie.
  - The pointer updates only on grant.
- **Requester rules**:
  - Hold `req` high until `ack` is seen, then drop `req` on the edge ending the `ack` cycle (or issue a new request).
  - Fields need only be valid at the grant edge, because they are latched.
  - Dropping `req` before grant withdraws the request. Dropping it after grant has no effect; the transfer completes.
- `ack` and `rdata` for non-granted requesters are never disturbed.

## Timing
- **Reset values**:
  - State IDLE, `enable`=0, `rw`=0, bus released (`bus_oe`=0).
  - `ack`=0, all `rdata`=0, pointer=0, grant index=0.
  - Reset is asynchronous. Asserting it mid-transfer aborts the transfer immediately: outputs go to reset values at once, no `ack` is issued, and the aborted write may or may not have reached memory.
- **Registered outputs**: `enable`, `rw`, `bus_oe`, the bus drive value and `ack` are all registered, with no combinational path from inputs.
- **Latency**: `req` sampled high at edge 0 (IDLE) gives ADDR in cycle 1, DATA in cycle 2 and `ack` in cycle 3. `rdata` is valid in the same cycle as `ack`.
- **Throughput**:
  - Back-to-back transfers to different requesters take 3 cycles each (DONE→ADDR).
  - The same requester re-requesting takes 4 cycles, because it is masked in DONE and passes through IDLE.
- **Bus turnaround**: in DONE the bus is released for one cycle, so there is never overlap between a read's RAM-driven phase and the next address phase.
- **Simultaneous requests**: exactly one grant per arbitration edge. Losers stay pending and are not dropped.

## Structure
- Package `ram_arbiter_pkg`:
  - `typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} arb_state_t`.
  - `localparam int RAM_W = 8`.
- Sub-module `rr_picker` (parameter N):
  - Inputs: `req`, `mask`, `ptr`.
  - Outputs: `grant_valid`, `grant_idx`.
  - Purely combinational round-robin priority search.
- The pointer register and the FSM live in `ram_arbiter`.
- Testbench `tb_ram_arbiter` instantiates `ram_arbiter` together with the real `ram`.

## Test plan
- **Single write**: req0 writes addr 10, data 15 → `ack[0]` in cycle 3; `ram.memory[10]`=15; `enable` high for exactly 2 cycles.
- **Single read**: after the write, req1 reads addr 10 → `ack[1]` in cycle 3 with `rdata[1]`=15; `rdata[0]` unchanged.
- **Simultaneous requests from reset**: req0 writes 0x20←0xAA and req1 writes 0x21←0x55 in the same cycle → requester 0 acked first, requester 1 acked exactly 3 cycles later; both memory cells correct.
- **Fairness**: req0 and req1 held high continuously for 6 transfers → acks alternate 0,1,0,1,0,1.
- **Same requester back to back**: req0 issues two reads with nothing else pending → 4-cycle spacing between acks; no duplicate ack.
- **Reset mid-transfer**: assert `reset` during ADDR of req0 write 0x30←0x77 → `enable`=0, bus released, `ack`=0 immediately; after release, a fresh req1 is granted first with pointer back at 0 behaviour.
